// File: rtl/lsu_axi_lite_master_if.sv
// Bundles the pipeline request/response ports and the five AXI-Lite channels of the LSU.
// The master modport is the LSU's view; the slave modport is the pipeline plus memory side.
interface lsu_axi_lite_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned NB = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NB-1:0]         wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/lsu_axi_lite_master.sv
// MEM-stage load/store unit: runs each request as one AXI-Lite transaction, handling lane
// steering, byte strobes, load extension, alignment checks and error responses.
module lsu_axi_lite_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  lsu_axi_lite_master_if.master   bus
);
  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned OB = $clog2(NB);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_DONE} state_t;

  state_t                state, state_next;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [OB-1:0]         off_q, off_d;
  logic                  aw_done, aw_done_d;
  logic                  w_done, w_done_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [NB-1:0]         wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  err_d;

  logic [OB-1:0]         req_off;
  logic [ADDR_WIDTH-1:0] req_mask;
  logic                  req_bad;
  logic [NB-1:0]         req_strb;
  logic [DATA_WIDTH-1:0] req_lanes;
  logic [DATA_WIDTH-1:0] req_shift;

  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] rd_ext;
  int unsigned           rd_bits;
  logic                  rd_sign;

  // Decode the incoming request: alignment check, strobes and lane-steered store data
  always_comb begin
    req_off   = bus.req_addr[OB-1:0];
    req_mask  = (ADDR_WIDTH'(1) << bus.req_size) - ADDR_WIDTH'(1);
    req_bad   = (32'(bus.req_size) > OB) || ((bus.req_addr & req_mask) != '0);
    req_strb  = ((NB'(1) << (4'd1 << bus.req_size)) - NB'(1)) << req_off;
    req_lanes = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      req_lanes[b*8 +: 8] = {8{req_strb[b]}};
    end
    req_shift = (bus.req_wdata << {req_off, 3'b000}) & req_lanes;
  end

  // Right-justify the addressed bytes of the read beat and extend to full width
  always_comb begin
    rd_shift = bus.rdata >> {off_q, 3'b000};
    rd_bits  = 32'd8 << size_q;
    rd_sign  = 1'b0;
    rd_ext   = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (i == rd_bits - 32'd1) rd_sign = rd_shift[i];
    end
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      rd_ext[i] = (i < rd_bits) ? rd_shift[i] : (signed_q & rd_sign);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next = state;
    size_d     = size_q;
    signed_d   = signed_q;
    off_d      = off_q;
    aw_done_d  = aw_done;
    w_done_d   = w_done;
    addr_d     = bus.araddr;
    wdata_d    = bus.wdata;
    wstrb_d    = bus.wstrb;
    rdata_d    = bus.resp_rdata;
    err_d      = bus.resp_err;

    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          off_d    = req_off;
          addr_d   = bus.req_addr & ~ADDR_WIDTH'(NB - 1);
          wdata_d  = req_shift;
          wstrb_d  = req_strb;
          if (req_bad) begin
            rdata_d    = '0;
            err_d      = 1'b1;
            state_next = S_DONE;
          end else begin
            state_next = bus.req_we ? S_WR : S_AR;
          end
        end
      end
      S_AR: begin
        if (bus.arready) state_next = S_R;
      end
      S_R: begin
        if (bus.rvalid) begin
          err_d      = (bus.rresp != 2'b00);
          rdata_d    = (bus.rresp != 2'b00) ? '0 : rd_ext;
          state_next = S_DONE;
        end
      end
      S_WR: begin
        // AW and W may complete in either order or together
        aw_done_d = aw_done | (bus.awvalid & bus.awready);
        w_done_d  = w_done  | (bus.wvalid  & bus.wready);
        if (aw_done_d && w_done_d) begin
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_next = S_B;
        end
      end
      S_B: begin
        if (bus.bvalid) begin
          err_d      = (bus.bresp != 2'b00);
          rdata_d    = '0;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State and registered outputs, decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      size_q         <= '0;
      signed_q       <= 1'b0;
      off_q          <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      bus.araddr     <= '0;
      bus.arvalid    <= 1'b0;
      bus.rready     <= 1'b0;
      bus.awaddr     <= '0;
      bus.awvalid    <= 1'b0;
      bus.wdata      <= '0;
      bus.wstrb      <= '0;
      bus.wvalid     <= 1'b0;
      bus.bready     <= 1'b0;
    end else begin
      state          <= state_next;
      size_q         <= size_d;
      signed_q       <= signed_d;
      off_q          <= off_d;
      aw_done        <= aw_done_d;
      w_done         <= w_done_d;
      bus.req_ready  <= (state_next == S_IDLE);
      bus.resp_valid <= (state_next == S_DONE);
      bus.resp_rdata <= rdata_d;
      bus.resp_err   <= err_d;
      bus.araddr     <= addr_d;
      bus.arvalid    <= (state_next == S_AR);
      bus.rready     <= (state_next == S_R);
      bus.awaddr     <= addr_d;
      bus.awvalid    <= (state_next == S_WR) && !aw_done_d;
      bus.wdata      <= wdata_d;
      bus.wstrb      <= wstrb_d;
      bus.wvalid     <= (state_next == S_WR) && !w_done_d;
      bus.bready     <= (state_next == S_B);
    end
  end
endmodule

// File: tb/tb_lsu_axi_lite_master.sv
// Table-driven bench for lsu_axi_lite_master: a sequential AXI-Lite slave answers each
// request while expected completions are queued and matched against resp_valid pulses.
module tb_lsu_axi_lite_master;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned NV = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_axi_lite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  lsu_axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] slv_rdata;
    logic [1:0]  slv_resp;
    int          lat_a;      // AR or AW ready delay
    int          lat_b;      // R or W delay
    int          lat_c;      // B delay
    logic        bad;
    logic [31:0] exp_addr;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;    // request cycle to resp_valid, 0 = unchecked
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          cyc;
    int          lat;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb [$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any completion pulse seen there
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!rst && bus.resp_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("resp_rdata", bus.resp_rdata, e.rdata);
        check("resp_err", 64'(bus.resp_err), 64'(e.err));
        if (e.lat != 0) check("resp_latency", 64'(cyc - e.cyc), 64'(e.lat));
      end
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [63:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int aw_n;
    int w_n;
    int k;
    check($sformatf("v%0d_req_ready", id), 64'(bus.req_ready), 64'd1);
    drive_req(v.we, v.size, v.sgn, v.addr, v.wdata);
    sb.push_back('{v.exp_rdata, v.exp_err, cyc, v.exp_lat});
    tick();
    bus.req_valid = 1'b0;
    if (v.bad) begin
      check($sformatf("v%0d_no_axi", id), 64'({bus.arvalid, bus.awvalid}), 64'd0);
      tick();
      check($sformatf("v%0d_no_axi_late", id), 64'({bus.arvalid, bus.awvalid}), 64'd0);
    end else if (!v.we) begin
      check($sformatf("v%0d_arvalid", id), 64'(bus.arvalid), 64'd1);
      check($sformatf("v%0d_araddr", id), 64'(bus.araddr), 64'(v.exp_addr));
      for (int j = 0; j < v.lat_a; j++) begin
        tick();
        check($sformatf("v%0d_arvalid_held", id), 64'({bus.arvalid, bus.araddr}),
              64'({1'b1, v.exp_addr}));
      end
      bus.arready = 1'b1;
      tick();
      bus.arready = 1'b0;
      check($sformatf("v%0d_r_phase", id), 64'({bus.arvalid, bus.rready}), 64'b01);
      for (int j = 0; j < v.lat_b; j++) tick();
      bus.rvalid = 1'b1;
      bus.rdata  = v.slv_rdata;
      bus.rresp  = v.slv_resp;
      tick();
      bus.rvalid = 1'b0;
      bus.rdata  = '0;
      bus.rresp  = 2'b00;
      check($sformatf("v%0d_rready_drop", id), 64'(bus.rready), 64'd0);
      tick();
    end else begin
      check($sformatf("v%0d_awaddr", id), 64'(bus.awaddr), 64'(v.exp_addr));
      check($sformatf("v%0d_wstrb", id), 64'(bus.wstrb), 64'(v.exp_strb));
      check($sformatf("v%0d_wdata", id), bus.wdata, v.exp_wdata);
      aw_n = 0;
      w_n  = 0;
      k    = 0;
      while ((aw_n == 0 || w_n == 0) && k < 50) begin
        check($sformatf("v%0d_awvalid_k%0d", id, k), 64'(bus.awvalid), 64'(aw_n == 0));
        check($sformatf("v%0d_wvalid_k%0d", id, k), 64'(bus.wvalid), 64'(w_n == 0));
        bus.awready = (aw_n == 0) && (k >= v.lat_a);
        bus.wready  = (w_n == 0) && (k >= v.lat_b);
        if (bus.awvalid && bus.awready) aw_n++;
        if (bus.wvalid && bus.wready) w_n++;
        tick();
        k++;
      end
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      check($sformatf("v%0d_aw_w_count", id), 64'({aw_n[7:0], w_n[7:0]}), 64'h0101);
      check($sformatf("v%0d_b_phase", id), 64'({bus.awvalid, bus.wvalid, bus.bready}), 64'b001);
      for (int j = 0; j < v.lat_c; j++) tick();
      bus.bvalid = 1'b1;
      bus.bresp  = v.slv_resp;
      tick();
      bus.bvalid = 1'b0;
      bus.bresp  = 2'b00;
      check($sformatf("v%0d_bready_drop", id), 64'(bus.bready), 64'd0);
      tick();
    end
    check($sformatf("v%0d_resp_seen", id), 64'(sb.size()), 64'd0);
  endtask

  // Reset in the R phase with the slave stalled must abandon the load silently
  task automatic reset_mid_read();
    drive_req(1'b0, 2'd2, 1'b0, 32'h0000_1000, 64'h0);
    sb.push_back('{64'h0, 1'b0, cyc, 0});
    tick();
    bus.req_valid = 1'b0;
    bus.arready   = 1'b1;
    tick();
    bus.arready = 1'b0;
    check("rst_pre_rready", 64'(bus.rready), 64'd1);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst_rready", 64'(bus.rready), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("rst_no_resp", 64'({bus.resp_valid, bus.arvalid, bus.rready}), 64'd0);
    end
    check("rst_cleared_result", {bus.resp_rdata[62:0], bus.resp_err}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion within time limit");
    $fatal(1);
  end

  initial begin
    //          we    sz    sg    addr          wdata                   slv_rdata               rsp    la lb lc bad   exp_addr      strb   exp_wdata               exp_rdata               err   lat
    vecs[0]  = '{1'b0, 2'd2, 1'b1, 32'h0000_1004, 64'h0,                 64'h8000_0001_1234_5678, 2'd0, 0, 0, 0, 1'b0, 32'h0000_1000, 8'h00, 64'h0,                 64'hFFFF_FFFF_8000_0001, 1'b0, 3};
    vecs[1]  = '{1'b1, 2'd0, 1'b0, 32'h0000_2003, 64'hAB,                64'h0,                   2'd0, 0, 0, 0, 1'b0, 32'h0000_2000, 8'h08, 64'h0000_0000_AB00_0000, 64'h0,                 1'b0, 3};
    vecs[2]  = '{1'b0, 2'd1, 1'b0, 32'h0000_1001, 64'h0,                 64'h0,                   2'd0, 0, 0, 0, 1'b1, 32'h0,         8'h00, 64'h0,                 64'h0,                 1'b1, 1};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0000_3007, 64'h0,                 64'h9A00_0000_0000_0000, 2'd0, 0, 0, 0, 1'b0, 32'h0000_3000, 8'h00, 64'h0,                 64'h0000_0000_0000_009A, 1'b0, 3};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h0000_3007, 64'h0,                 64'h9A00_0000_0000_0000, 2'd0, 0, 0, 0, 1'b0, 32'h0000_3000, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FF9A, 1'b0, 3};
    vecs[5]  = '{1'b0, 2'd3, 1'b1, 32'h0000_4008, 64'h0,                 64'h8123_4567_89AB_CDEF, 2'd0, 0, 0, 0, 1'b0, 32'h0000_4008, 8'h00, 64'h0,                 64'h8123_4567_89AB_CDEF, 1'b0, 3};
    vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h0000_5006, 64'h0,                 64'h7FFF_1111_2222_3333, 2'd0, 0, 0, 0, 1'b0, 32'h0000_5000, 8'h00, 64'h0,                 64'h0000_0000_0000_7FFF, 1'b0, 3};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h0000_6002, 64'hFFFF_FFFF_FFFF_BEEF, 64'h0,                   2'd0, 0, 0, 0, 1'b0, 32'h0000_6000, 8'h0C, 64'h0000_0000_BEEF_0000, 64'h0,                 1'b0, 3};
    vecs[8]  = '{1'b1, 2'd3, 1'b0, 32'h0000_7000, 64'h1122_3344_5566_7788, 64'h0,                   2'd0, 0, 0, 2, 1'b0, 32'h0000_7000, 8'hFF, 64'h1122_3344_5566_7788, 64'h0,                 1'b0, 5};
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h0000_8002, 64'h1234,              64'h0,                   2'd0, 0, 0, 0, 1'b1, 32'h0,         8'h00, 64'h0,                 64'h0,                 1'b1, 1};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h0000_9000, 64'h0,                 64'hDEAD_BEEF_DEAD_BEEF, 2'd2, 0, 0, 0, 1'b0, 32'h0000_9000, 8'h00, 64'h0,                 64'h0,                 1'b1, 3};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h0000_9004, 64'h0,                 64'h1234_5678_0000_0000, 2'd0, 0, 0, 0, 1'b0, 32'h0000_9000, 8'h00, 64'h0,                 64'h0000_0000_1234_5678, 1'b0, 3};
    vecs[12] = '{1'b1, 2'd2, 1'b0, 32'h0000_A004, 64'hCAFE_F00D,         64'h0,                   2'd2, 0, 0, 0, 1'b0, 32'h0000_A000, 8'hF0, 64'hCAFE_F00D_0000_0000, 64'h0,                 1'b1, 3};
    vecs[13] = '{1'b1, 2'd0, 1'b0, 32'h0000_B001, 64'h55,                64'h0,                   2'd0, 0, 3, 0, 1'b0, 32'h0000_B000, 8'h02, 64'h0000_0000_0000_5500, 64'h0,                 1'b0, 6};
    vecs[14] = '{1'b1, 2'd1, 1'b0, 32'h0000_C00E, 64'h1234,              64'h0,                   2'd0, 2, 0, 0, 1'b0, 32'h0000_C008, 8'hC0, 64'h1234_0000_0000_0000, 64'h0,                 1'b0, 5};
    vecs[15] = '{1'b0, 2'd1, 1'b0, 32'h0000_D00A, 64'h0,                 64'h0000_0000_F00D_0000, 2'd0, 2, 2, 0, 1'b0, 32'h0000_D008, 8'h00, 64'h0,                 64'h0000_0000_0000_F00D, 1'b0, 7};

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.arready    = 1'b0;
    bus.rdata      = '0;
    bus.rresp      = 2'b00;
    bus.rvalid     = 1'b0;
    bus.awready    = 1'b0;
    bus.wready     = 1'b0;
    bus.bresp      = 2'b00;
    bus.bvalid     = 1'b0;

    tick();
    tick();
    check("reset_req_ready", 64'(bus.req_ready), 64'd1);
    check("reset_valids", 64'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.resp_valid}), 64'd0);
    check("reset_resp_rdata", bus.resp_rdata, 64'd0);
    check("reset_resp_err", 64'(bus.resp_err), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < int'(NV); i++) run_vec(vecs[i], i);
    reset_mid_read();
    run_vec(vecs[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
